// File: rtl/pck_len_ctrl.sv
// -----------------------------------------------------------------------------
// pck_len_ctrl
//
// Sequencer around a packet-length FIFO.
//   Write side: counts the beats of each ingress packet, checks the length
//   when EOP arrives and either pushes one length entry into the FIFO or
//   rejects the packet (short / long / FIFO full / protocol abort).
//   Read side: pops one length entry when downstream is ready and replays it
//   as a counted beat stream with start and last markers.
//
// Ports
//   clk          clock
//   hw_rst       asynchronous active-low reset
//   sw_rst       synchronous active-high soft reset, same effect as hw_rst
//   in_valid     ingress beat valid
//   in_sop       ingress start of packet (qualified by in_valid)
//   in_eop       ingress end of packet (qualified by in_valid)
//   len_wr_en    FIFO write strobe (registered, one cycle after EOP)
//   len_wr_data  length written to the FIFO
//   len_full     FIFO full
//   len_empty    FIFO empty
//   len_rd_en    FIFO read strobe
//   len_rd_data  FIFO read data, valid the cycle after len_rd_en
//   out_ready    downstream can accept a beat
//   out_start    pulse: new replayed packet begins, out_len valid
//   out_valid    egress beat valid
//   out_last     final beat of the replayed packet
//   out_len      length of the packet being replayed
//   err_short    pulse: packet rejected, length < MIN_LEN
//   err_long     pulse: packet rejected, length > MAX_LEN
//   err_proto    pulse: SOP inside a packet, or beat without SOP while idle
//   pkt_cnt      accepted packets, saturating
//   drop_cnt     rejected packets, saturating
// -----------------------------------------------------------------------------
module pck_len_ctrl #(
    parameter int LEN_WIDTH = 12,
    parameter int MIN_LEN   = 4,
    parameter int MAX_LEN   = 1500,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 hw_rst,
    input  logic                 sw_rst,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic                 len_wr_en,
    output logic [LEN_WIDTH-1:0] len_wr_data,
    input  logic                 len_full,
    input  logic                 len_empty,
    output logic                 len_rd_en,
    input  logic [LEN_WIDTH-1:0] len_rd_data,
    input  logic                 out_ready,
    output logic                 out_start,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [LEN_WIDTH-1:0] out_len,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 err_proto,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic {
        W_IDLE,
        W_PKT
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DRAIN
    } rstate_t;

    localparam logic [LEN_WIDTH-1:0] L_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] L_MIN = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] L_MAX = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] L_SAT = {LEN_WIDTH{1'b1}};

    // Beat counter increment that sticks at all-ones.
    function automatic logic [LEN_WIDTH-1:0] len_sat_inc(input logic [LEN_WIDTH-1:0] v);
        return (v == L_SAT) ? v : v + L_ONE;
    endfunction

    // Statistics counter add of 0..2 that holds at all-ones.
    function automatic logic [CNT_WIDTH-1:0] cnt_sat_add(
        input logic [CNT_WIDTH-1:0] v,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, v} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    wstate_t                r_wstate;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic                   r_wr_en;
    logic [LEN_WIDTH-1:0]   r_wr_data;
    logic                   r_err_short;
    logic                   r_err_long;
    logic                   r_err_proto;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt;
    logic [CNT_WIDTH-1:0]   r_drop_cnt;

    rstate_t                r_rstate;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [LEN_WIDTH-1:0]   r_out_len;
    logic                   r_out_start;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    wstate_t                w_wstate_nxt;
    logic [LEN_WIDTH-1:0]   w_beat_nxt;
    logic                   w_eval;
    logic                   w_abort;
    logic                   w_stray;
    logic                   w_short;
    logic                   w_long;
    logic                   w_legal;
    logic                   w_write;
    logic                   w_full_drop;
    logic                   w_reject;
    logic [1:0]             w_drop_inc;

    rstate_t                w_rstate_nxt;
    logic                   w_rd_req;
    logic                   w_beat;
    logic                   w_len_load;
    logic                   w_start_nxt;
    logic [LEN_WIDTH-1:0]   w_rem_nxt;

    // Low while either reset is active. The combinational strobes are gated
    // with it so a reset cycle can never pop the FIFO or emit a beat.
    logic                   w_active;

    assign w_active = hw_rst & ~sw_rst;

    // -------------------------------------------------------------------------
    // Write FSM: next state and beat counting
    // -------------------------------------------------------------------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_beat_nxt   = r_beat_cnt;
        w_eval       = 1'b0;
        w_abort      = 1'b0;
        w_stray      = 1'b0;

        case (r_wstate)
            W_IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        w_beat_nxt = L_ONE;
                        if (in_eop) begin
                            w_eval = 1'b1;       // 1-beat packet, judge now
                        end else begin
                            w_wstate_nxt = W_PKT;
                        end
                    end else begin
                        w_stray = 1'b1;          // beat outside any packet
                    end
                end
            end
            W_PKT: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // New SOP kills the open packet and starts a fresh one.
                        w_abort    = 1'b1;
                        w_beat_nxt = L_ONE;
                    end else begin
                        w_beat_nxt = len_sat_inc(r_beat_cnt);
                    end
                    if (in_eop) begin
                        w_eval       = 1'b1;
                        w_wstate_nxt = W_IDLE;
                    end
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Length judgement uses the count including the EOP beat.
    assign w_short     = w_eval & (w_beat_nxt < L_MIN);
    assign w_long      = w_eval & (w_beat_nxt > L_MAX);
    assign w_legal     = w_eval & ~w_short & ~w_long;
    assign w_write     = w_legal & ~len_full;
    assign w_full_drop = w_legal & len_full;
    assign w_reject    = w_short | w_long | w_full_drop;
    // An abort and a short 1-beat replacement can both land in one cycle.
    assign w_drop_inc  = {1'b0, w_abort} + {1'b0, w_reject};

    // -------------------------------------------------------------------------
    // Write FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_wstate <= W_IDLE;
        end else if (sw_rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Write side registered outputs and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_beat_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_proto <= 1'b0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else if (sw_rst) begin
            r_beat_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_proto <= 1'b0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_beat_cnt  <= w_beat_nxt;
            r_wr_en     <= w_write;
            if (w_write) begin
                r_wr_data <= w_beat_nxt;
                r_pkt_cnt <= cnt_sat_add(r_pkt_cnt, 2'd1);
            end
            r_err_short <= w_short;
            r_err_long  <= w_long;
            r_err_proto <= w_abort | w_stray;
            r_drop_cnt  <= cnt_sat_add(r_drop_cnt, w_drop_inc);
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM: next state, pop request and beat generation
    // -------------------------------------------------------------------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_req     = 1'b0;
        w_beat       = 1'b0;
        w_len_load   = 1'b0;
        w_start_nxt  = 1'b0;
        w_rem_nxt    = r_remaining;

        case (r_rstate)
            R_IDLE: begin
                if (!len_empty && out_ready) begin
                    w_rd_req     = 1'b1;
                    w_rstate_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                // FIFO data is valid now, one cycle after the pop.
                w_len_load = 1'b1;
                w_rem_nxt  = len_rd_data;
                if (len_rd_data != '0) begin
                    w_start_nxt  = 1'b1;
                    w_rstate_nxt = R_DRAIN;
                end else begin
                    w_rstate_nxt = R_IDLE;   // zero-length entry: nothing to replay
                end
            end
            R_DRAIN: begin
                if (out_ready) begin
                    w_beat    = 1'b1;
                    w_rem_nxt = r_remaining - L_ONE;
                    if (r_remaining == L_ONE) begin
                        w_rstate_nxt = R_IDLE;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_rstate <= R_IDLE;
        end else if (sw_rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Read side registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_remaining <= '0;
            r_out_len   <= '0;
            r_out_start <= 1'b0;
        end else if (sw_rst) begin
            r_remaining <= '0;
            r_out_len   <= '0;
            r_out_start <= 1'b0;
        end else begin
            r_remaining <= w_rem_nxt;
            r_out_start <= w_start_nxt;
            if (w_len_load) begin
                r_out_len <= len_rd_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign len_wr_en   = r_wr_en;
    assign len_wr_data = r_wr_data;
    assign len_rd_en   = w_rd_req & w_active;
    // out_start is registered out of R_FETCH, so it lines up with the first
    // R_DRAIN cycle, when out_len already holds the fetched length.
    assign out_start   = r_out_start;
    assign out_valid   = w_beat & w_active;
    assign out_last    = out_valid & (r_remaining == L_ONE);
    assign out_len     = r_out_len;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign err_proto   = r_err_proto;
    assign pkt_cnt     = r_pkt_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pck_len_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pck_len_ctrl
//
// Directed bench for pck_len_ctrl. A behavioural 32-entry length FIFO sits
// between the write and read sides of the DUT. Negedge monitors log FIFO
// writes, replayed packet starts, beats and error pulses; each test task
// drives its scenario and compares the logged deltas against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_pck_len_ctrl;

    localparam int LW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          hw_rst = 1'b0;
    logic          sw_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          len_wr_en;
    logic [LW-1:0] len_wr_data;
    logic          len_full;
    logic          len_empty;
    logic          len_rd_en;
    logic [LW-1:0] len_rd_data;
    logic          out_ready = 1'b0;
    logic          out_start;
    logic          out_valid;
    logic          out_last;
    logic [LW-1:0] out_len;
    logic          err_short;
    logic          err_long;
    logic          err_proto;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    pck_len_ctrl #(
        .LEN_WIDTH(LW),
        .MIN_LEN  (4),
        .MAX_LEN  (1500),
        .CNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .hw_rst     (hw_rst),
        .sw_rst     (sw_rst),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .len_wr_en  (len_wr_en),
        .len_wr_data(len_wr_data),
        .len_full   (len_full),
        .len_empty  (len_empty),
        .len_rd_en  (len_rd_en),
        .len_rd_data(len_rd_data),
        .out_ready  (out_ready),
        .out_start  (out_start),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_len    (out_len),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_proto  (err_proto),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt)
    );

    // Behavioural length FIFO: depth 32, registered read data.
    logic [LW-1:0] fmem [0:31];
    int            fcnt = 0;
    int            fwp = 0;
    int            frp = 0;
    logic [LW-1:0] frd = '0;

    always @(posedge clk) begin
        if (len_wr_en && fcnt < 32) begin
            fmem[fwp] <= len_wr_data;
            fwp <= (fwp + 1) % 32;
        end
        if (len_rd_en && fcnt > 0) begin
            frd <= fmem[frp];
            frp <= (frp + 1) % 32;
        end
        fcnt <= fcnt + ((len_wr_en && fcnt < 32) ? 1 : 0) - ((len_rd_en && fcnt > 0) ? 1 : 0);
    end

    assign len_full    = (fcnt == 32);
    assign len_empty   = (fcnt == 0);
    assign len_rd_data = frd;

    // Monitors
    int cyc = 0;
    int wr_n = 0, rd_n = 0, start_n = 0, beat_n = 0, last_n = 0;
    int short_n = 0, long_n = 0, proto_n = 0, bad_n = 0;
    int wr_cyc = 0, eop_cyc = 0, beat_idx = 0, last_idx = 0;
    int wr_log [0:255];
    int start_log [0:255];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_eop) eop_cyc = cyc;
        if (len_wr_en) begin
            wr_log[wr_n % 256] = int'(len_wr_data);
            wr_n = wr_n + 1;
            wr_cyc = cyc;
        end
        if (len_rd_en) rd_n = rd_n + 1;
        if (out_start) begin
            start_log[start_n % 256] = int'(out_len);
            start_n = start_n + 1;
            beat_idx = 0;
        end
        if (out_valid) begin
            beat_n = beat_n + 1;
            beat_idx = beat_idx + 1;
            if (out_last) begin
                last_n = last_n + 1;
                last_idx = beat_idx;
            end
        end
        if (out_valid && !out_ready) bad_n = bad_n + 1;
        if (out_last && !out_valid) bad_n = bad_n + 1;
        if (err_short) short_n = short_n + 1;
        if (err_long) long_n = long_n + 1;
        if (err_proto) proto_n = proto_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] all_out;
        hw_rst = 1'b0;
        out_ready = 1'b1;
        idle(3);
        all_out = {len_wr_en, len_wr_data, len_rd_en, out_start, out_valid, out_last,
                   out_len, err_short, err_long, err_proto, pkt_cnt, drop_cnt};
        checks++;
        if (all_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        hw_rst = 1'b1;
        idle(2);
        checks++;
        if ({pkt_cnt, drop_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h expected 0", {pkt_cnt, drop_cnt});
        end
    endtask

    task automatic test_single();
        int b_wr = wr_n, b_rd = rd_n, b_st = start_n, b_bt = beat_n, b_ls = last_n;
        out_ready = 1'b1;
        send_pkt(6);
        idle(20);
        checks++;
        if (wr_n - b_wr != 1) begin errors++; $display("FAIL single_writes: got %0d expected 1", wr_n - b_wr); end
        checks++;
        if (wr_log[b_wr] != 6) begin errors++; $display("FAIL single_wr_data: got %0d expected 6", wr_log[b_wr]); end
        checks++;
        if (wr_cyc != eop_cyc + 1) begin errors++; $display("FAIL single_wr_latency: got %0d expected 1", wr_cyc - eop_cyc); end
        checks++;
        if (rd_n - b_rd != 1) begin errors++; $display("FAIL single_reads: got %0d expected 1", rd_n - b_rd); end
        checks++;
        if (start_n - b_st != 1 || start_log[b_st] != 6) begin
            errors++; $display("FAIL single_start: got %0d starts len %0d expected 1 len 6", start_n - b_st, start_log[b_st]);
        end
        checks++;
        if (beat_n - b_bt != 6) begin errors++; $display("FAIL single_beats: got %0d expected 6", beat_n - b_bt); end
        checks++;
        if (last_n - b_ls != 1 || last_idx != 6) begin
            errors++; $display("FAIL single_last: got %0d lasts at beat %0d expected 1 at 6", last_n - b_ls, last_idx);
        end
        checks++;
        if (pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL single_counts: got pkt %0d drop %0d expected 1 0", pkt_cnt, drop_cnt);
        end
    endtask

    task automatic test_errors();
        int b_wr = wr_n, b_sh = short_n, b_lg = long_n;
        send_pkt(3);
        idle(2);
        send_pkt(1);
        idle(2);
        send_pkt(1600);
        idle(3);
        checks++;
        if (short_n - b_sh != 2) begin errors++; $display("FAIL err_short_pulses: got %0d expected 2", short_n - b_sh); end
        checks++;
        if (long_n - b_lg != 1) begin errors++; $display("FAIL err_long_pulses: got %0d expected 1", long_n - b_lg); end
        checks++;
        if (wr_n - b_wr != 0) begin errors++; $display("FAIL err_no_write: got %0d expected 0", wr_n - b_wr); end
        checks++;
        if (drop_cnt !== 16'd3 || pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL err_counts: got drop %0d pkt %0d expected 3 1", drop_cnt, pkt_cnt);
        end
    endtask

    task automatic test_bounds();
        int b_wr = wr_n, b_st = start_n, b_bt = beat_n;
        out_ready = 1'b1;
        send_pkt(4);
        idle(15);
        send_pkt(1500);
        idle(1520);
        checks++;
        if (wr_n - b_wr != 2 || wr_log[b_wr] != 4 || wr_log[b_wr + 1] != 1500) begin
            errors++; $display("FAIL bounds_writes: got %0d writes (%0d,%0d) expected 2 (4,1500)", wr_n - b_wr, wr_log[b_wr], wr_log[b_wr + 1]);
        end
        checks++;
        if (start_n - b_st != 2 || start_log[b_st + 1] != 1500) begin
            errors++; $display("FAIL bounds_starts: got %0d len %0d expected 2 len 1500", start_n - b_st, start_log[b_st + 1]);
        end
        checks++;
        if (beat_n - b_bt != 1504) begin errors++; $display("FAIL bounds_beats: got %0d expected 1504", beat_n - b_bt); end
        checks++;
        if (pkt_cnt !== 16'd3 || drop_cnt !== 16'd3) begin
            errors++; $display("FAIL bounds_counts: got pkt %0d drop %0d expected 3 3", pkt_cnt, drop_cnt);
        end
    endtask

    task automatic test_fill();
        int b_wr = wr_n, b_rd = rd_n, b_st = start_n, b_bt = beat_n, b_ls = last_n;
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) send_pkt(4 + k);
        send_pkt(7);
        idle(3);
        checks++;
        if (wr_n - b_wr != 32) begin errors++; $display("FAIL fill_writes: got %0d expected 32", wr_n - b_wr); end
        checks++;
        if (rd_n - b_rd != 0) begin errors++; $display("FAIL fill_no_read: got %0d expected 0", rd_n - b_rd); end
        checks++;
        if (drop_cnt !== 16'd4 || pkt_cnt !== 16'd35) begin
            errors++; $display("FAIL fill_counts: got drop %0d pkt %0d expected 4 35", drop_cnt, pkt_cnt);
        end
        out_ready = 1'b1;
        idle(800);
        checks++;
        if (start_n - b_st != 32) begin errors++; $display("FAIL fill_starts: got %0d expected 32", start_n - b_st); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (start_log[b_st + k] != 4 + k) begin
                errors++; $display("FAIL fill_order_%0d: got %0d expected %0d", k, start_log[b_st + k], 4 + k);
            end
        end
        checks++;
        if (beat_n - b_bt != 624 || last_n - b_ls != 32) begin
            errors++; $display("FAIL fill_beats: got %0d beats %0d lasts expected 624 32", beat_n - b_bt, last_n - b_ls);
        end
    endtask

    task automatic test_proto();
        int b_wr = wr_n, b_pr = proto_n;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sop = 1'b0;
        in_eop = 1'b0;
        tick();
        in_valid = 1'b0;
        idle(2);
        checks++;
        if (proto_n - b_pr != 1 || drop_cnt !== 16'd4) begin
            errors++; $display("FAIL proto_stray: got %0d pulses drop %0d expected 1 4", proto_n - b_pr, drop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 4);
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        idle(15);
        checks++;
        if (proto_n - b_pr != 2) begin errors++; $display("FAIL proto_abort_pulse: got %0d expected 2", proto_n - b_pr); end
        checks++;
        if (wr_n - b_wr != 1 || wr_log[b_wr] != 5) begin
            errors++; $display("FAIL proto_write: got %0d writes len %0d expected 1 len 5", wr_n - b_wr, wr_log[b_wr]);
        end
        checks++;
        if (drop_cnt !== 16'd5 || pkt_cnt !== 16'd36) begin
            errors++; $display("FAIL proto_counts: got drop %0d pkt %0d expected 5 36", drop_cnt, pkt_cnt);
        end
    endtask

    task automatic test_toggle();
        int b_st = start_n, b_bt = beat_n, b_ls = last_n, b_bad = bad_n;
        out_ready = 1'b0;
        send_pkt(10);
        idle(4);
        for (int i = 0; i < 60; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        idle(5);
        checks++;
        if (start_n - b_st != 1 || start_log[b_st] != 10) begin
            errors++; $display("FAIL toggle_start: got %0d starts len %0d expected 1 len 10", start_n - b_st, start_log[b_st]);
        end
        checks++;
        if (beat_n - b_bt != 10) begin errors++; $display("FAIL toggle_beats: got %0d expected 10", beat_n - b_bt); end
        checks++;
        if (last_n - b_ls != 1 || last_idx != 10) begin
            errors++; $display("FAIL toggle_last: got %0d lasts at beat %0d expected 1 at 10", last_n - b_ls, last_idx);
        end
        checks++;
        if (bad_n - b_bad != 0) begin errors++; $display("FAIL toggle_handshake: got %0d violations expected 0", bad_n - b_bad); end
    endtask

    task automatic test_sw_rst();
        int b_wr, b_bt, b_ls, b_pr;
        logic [7:0] strobes;
        out_ready = 1'b1;
        b_bt = beat_n;
        b_ls = last_n;
        send_pkt(20);
        idle(8);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        strobes = {len_wr_en, len_rd_en, out_start, out_valid, out_last, err_short, err_long, err_proto};
        checks++;
        if (strobes !== 8'd0 || out_len !== 12'd0 || len_wr_data !== 12'd0) begin
            errors++; $display("FAIL swrst_drain_outputs: got strobes %b len %0d wdata %0d expected 0", strobes, out_len, len_wr_data);
        end
        checks++;
        if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL swrst_counters: got pkt %0d drop %0d expected 0 0", pkt_cnt, drop_cnt);
        end
        idle(30);
        checks++;
        if (beat_n - b_bt != 5 || last_n - b_ls != 0) begin
            errors++; $display("FAIL swrst_drain_cut: got %0d beats %0d lasts expected 5 0", beat_n - b_bt, last_n - b_ls);
        end
        b_wr = wr_n;
        b_pr = proto_n;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0;
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_eop = (i == 2);
            tick();
        end
        in_valid = 1'b0; in_eop = 1'b0;
        idle(5);
        checks++;
        if (wr_n - b_wr != 0 || pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL swrst_partial_discard: got %0d writes pkt %0d expected 0 0", wr_n - b_wr, pkt_cnt);
        end
        checks++;
        if (proto_n - b_pr != 3 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL swrst_stray_after: got %0d pulses drop %0d expected 3 0", proto_n - b_pr, drop_cnt);
        end
        send_pkt(5);
        idle(15);
        checks++;
        if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL swrst_recover: got pkt %0d expected 1", pkt_cnt); end
        #3;
        hw_rst = 1'b0;
        #1;
        checks++;
        if (pkt_cnt !== 16'd0 || out_len !== 12'd0) begin
            errors++; $display("FAIL hwrst_async: got pkt %0d len %0d expected 0 0", pkt_cnt, out_len);
        end
        tick();
        hw_rst = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_bounds();
        test_fill();
        test_proto();
        test_toggle();
        test_sw_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
